// File: rtl/imem_loader_pkg.sv
// Shared loader constants and FSM encoding, also imported by the CPU top.
package imem_loader_pkg;

  localparam int LOADER_DEPTH  = 256;
  localparam int LOADER_ADDR_W = 8;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words and emits a one-cycle
// word_valid pulse with the finished (zero-padded on last) word.
module word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_byte,
  input  logic        strobe,
  input  logic        last,
  output logic        completing,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx_reg;
  logic [31:0] merged;
  logic [31:0] word_reg;
  logic        valid_reg;

  assign completing = strobe && (last || idx_reg == 2'd3);

  // Each lane holds its byte until the word completes; lanes above the
  // current index stay zero, which gives the zero pad on a short last word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_reg;
      logic       hit;

      assign hit = strobe && (idx_reg == 2'(gi));
      assign merged[8*gi +: 8] = hit ? data_byte : lane_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg <= 8'd0;
        end else if (completing) begin
          lane_reg <= 8'd0;
        end else if (hit) begin
          lane_reg <= data_byte;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg   <= 2'd0;
      word_reg  <= 32'd0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= completing;
      if (completing) begin
        idx_reg  <= 2'd0;
        word_reg <= merged;
      end else if (strobe) begin
        idx_reg <= idx_reg + 2'd1;
      end
    end
  end

  assign word_valid = valid_reg;
  assign word       = word_reg;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: zero-fills the memory, then streams program
// bytes into it as words and raises start_o when the program is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = LOADER_DEPTH,
  parameter int ADDR_W = LOADER_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        byte_i,
  input  logic              valid_i,
  input  logic              last_i,
  output logic              ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              start_o,
  output logic [ADDR_W:0]   words_o,
  output logic              overflow_o
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_addr_reg;
  logic [ADDR_W:0]   words_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic              overflow_reg;

  logic        ready;
  logic        clearing;
  logic        accept;
  logic        full;
  logic        pack_strobe;
  logic        completing;
  logic        word_valid;
  logic [31:0] word;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= CLEAR;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    clearing   = 1'b0;
    case (state_reg)
      CLEAR: begin
        // Masked by rst_i so no write strobe leaks out while held in reset.
        clearing = rst_i;
        if (clr_addr_reg == ADDR_W'(DEPTH - 1)) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        ready = 1'b1;
        if (valid_i && last_i) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  assign accept      = valid_i && ready;
  assign full        = (words_reg == (ADDR_W + 1)'(DEPTH));
  assign pack_strobe = accept && !full;

  word_packer u_packer (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .data_byte  (byte_i),
    .strobe     (pack_strobe),
    .last       (last_i),
    .completing (completing),
    .word_valid (word_valid),
    .word       (word)
  );

  // The write address is captured when the word completes, so words_o
  // already shows the new count during the write cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      clr_addr_reg <= '0;
      words_reg    <= '0;
      wr_addr_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (state_reg == CLEAR) begin
        clr_addr_reg <= clr_addr_reg + 1'b1;
      end
      if (completing) begin
        words_reg   <= words_reg + 1'b1;
        wr_addr_reg <= words_reg[ADDR_W-1:0];
      end
      if (accept && full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign ready_o     = ready;
  assign imem_we_o   = clearing || word_valid;
  assign imem_addr_o = clearing ? clr_addr_reg : (word_valid ? wr_addr_reg : '0);
  assign imem_data_o = word_valid ? word : 32'd0;
  assign start_o     = (state_reg == DONE);
  assign words_o     = words_reg;
  assign overflow_o  = overflow_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with hand-computed expectations.
module tb_imem_loader;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] byte_i;
  logic       valid_i;
  logic       last_i;
  logic       ready_o;
  logic       imem_we_o;
  logic [7:0] imem_addr_o;
  logic [31:0] imem_data_o;
  logic       start_o;
  logic [8:0] words_o;
  logic       overflow_o;

  int checks = 0;
  int errors = 0;

  imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .byte_i      (byte_i),
    .valid_i     (valid_i),
    .last_i      (last_i),
    .ready_o     (ready_o),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_data_o (imem_data_o),
    .start_o     (start_o),
    .words_o     (words_o),
    .overflow_o  (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(ready_o), 32'd0);
    check({tag, "_we"}, 32'(imem_we_o), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr_o), 32'd0);
    check({tag, "_data"}, imem_data_o, 32'd0);
    check({tag, "_start"}, 32'(start_o), 32'd0);
    check({tag, "_words"}, 32'(words_o), 32'd0);
    check({tag, "_ovf"}, 32'(overflow_o), 32'd0);
  endtask

  task automatic push(input logic [7:0] b, input logic l);
    byte_i  = b;
    last_i  = l;
    valid_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic idle();
    valid_i = 1'b0;
    last_i  = 1'b1;
    byte_i  = 8'hFF;
    @(negedge clk_i);
  endtask

  task automatic reset_and_clear(input string tag);
    int n;
    valid_i = 1'b0;
    last_i  = 1'b0;
    rst_i   = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    n = 0;
    while (!ready_o && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_clear_cycles"}, 32'(n), 32'd256);
  endtask

  logic [31:0] exp_word;

  initial begin
    rst_i   = 1'b0;
    byte_i  = 8'h00;
    valid_i = 1'b0;
    last_i  = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_values("reset");

    // Zero fill: one write per cycle, addresses 0..255
    rst_i = 1'b1;
    for (int i = 0; i < 256; i++) begin
      #1;
      check("clr_we", 32'(imem_we_o), 32'd1);
      check("clr_addr", 32'(imem_addr_o), 32'(i));
      check("clr_data", imem_data_o, 32'd0);
      @(negedge clk_i);
    end
    check("load_ready", 32'(ready_o), 32'd1);
    check("load_we", 32'(imem_we_o), 32'd0);
    check("load_start", 32'(start_o), 32'd0);

    // Back-to-back word
    push(8'h13, 1'b0);
    push(8'h05, 1'b0);
    push(8'h50, 1'b0);
    push(8'h00, 1'b0);
    valid_i = 1'b0;
    check("w0_we", 32'(imem_we_o), 32'd1);
    check("w0_addr", 32'(imem_addr_o), 32'd0);
    check("w0_data", imem_data_o, 32'h00500513);
    check("w0_words", 32'(words_o), 32'd1);
    @(negedge clk_i);
    check("w0_pulse_end", 32'(imem_we_o), 32'd0);
    check("w0_idle_data", imem_data_o, 32'd0);

    // Same stream with valid toggling; last_i on idle cycles must be ignored
    push(8'h13, 1'b0); idle();
    push(8'h05, 1'b0); idle();
    push(8'h50, 1'b0); idle();
    check("gap_ready", 32'(ready_o), 32'd1);
    check("gap_no_we", 32'(imem_we_o), 32'd0);
    push(8'h00, 1'b0);
    valid_i = 1'b0;
    last_i  = 1'b0;
    check("w1_we", 32'(imem_we_o), 32'd1);
    check("w1_addr", 32'(imem_addr_o), 32'd1);
    check("w1_data", imem_data_o, 32'h00500513);
    check("w1_words", 32'(words_o), 32'd2);
    check("w1_start", 32'(start_o), 32'd0);

    // Six bytes, last on the sixth: partial word zero padded
    reset_and_clear("six");
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    push(8'h04, 1'b0);
    check("six_w0_we", 32'(imem_we_o), 32'd1);
    check("six_w0_addr", 32'(imem_addr_o), 32'd0);
    check("six_w0_data", imem_data_o, 32'h04030201);
    push(8'h05, 1'b0);
    check("six_mid_we", 32'(imem_we_o), 32'd0);
    push(8'h06, 1'b1);
    check("six_w1_we", 32'(imem_we_o), 32'd1);
    check("six_w1_addr", 32'(imem_addr_o), 32'd1);
    check("six_w1_data", imem_data_o, 32'h00000605);
    check("six_start", 32'(start_o), 32'd1);
    check("six_ready", 32'(ready_o), 32'd0);
    check("six_words", 32'(words_o), 32'd2);
    byte_i = 8'h77;
    last_i = 1'b0;
    @(negedge clk_i);
    check("done_we", 32'(imem_we_o), 32'd0);
    check("done_start", 32'(start_o), 32'd1);
    check("done_words", 32'(words_o), 32'd2);
    valid_i = 1'b0;

    // Reset mid-load after 10 bytes
    reset_and_clear("abort");
    for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i), 1'b0);
    valid_i = 1'b0;
    rst_i   = 1'b0;
    #1;
    check_reset_values("abort_rst");
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("abort_restart_we", 32'(imem_we_o), 32'd1);
    check("abort_restart_addr", 32'(imem_addr_o), 32'd0);
    begin
      int n;
      n = 0;
      while (!ready_o && n < 400) begin
        @(negedge clk_i);
        n++;
      end
      check("abort_clear_done", 32'(ready_o), 32'd1);
    end
    push(8'hAA, 1'b1);
    valid_i = 1'b0;
    check("single_we", 32'(imem_we_o), 32'd1);
    check("single_addr", 32'(imem_addr_o), 32'd0);
    check("single_data", imem_data_o, 32'h000000AA);
    check("single_words", 32'(words_o), 32'd1);
    check("single_start", 32'(start_o), 32'd1);

    // 1028 bytes: memory fills, the last four bytes are dropped
    reset_and_clear("ovf");
    for (int i = 0; i < 1028; i++) begin
      push(8'(i), (i == 1027));
      if ((i % 4) == 3 && i < 1024) begin
        exp_word = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
        check("ovf_we", 32'(imem_we_o), 32'd1);
        check("ovf_addr", 32'(imem_addr_o), 32'(i / 4));
        check("ovf_data", imem_data_o, exp_word);
      end else begin
        check("ovf_no_we", 32'(imem_we_o), 32'd0);
      end
      if (i == 1023) check("ovf_before", 32'(overflow_o), 32'd0);
      if (i == 1024) check("ovf_after", 32'(overflow_o), 32'd1);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    check("ovf_start", 32'(start_o), 32'd1);
    check("ovf_words", 32'(words_o), 32'd256);
    check("ovf_ready", 32'(ready_o), 32'd0);
    @(negedge clk_i);
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    check("ovf_final_we", 32'(imem_we_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
